// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory-ready handshake, timeout abort and illegal-opcode pulse.
// Optional feature: define CTRL_BNE_EN to decode BNE (000101) into the branch state.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCWriteCondNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       mem_err,
    output logic       illegal
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef CTRL_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        WB_MEM  = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        ALU_WB  = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ADDI_EX = 4'd10,
        ADDI_WB = 4'd11
    } stateT;

    stateT            curState;
    stateT            nextState;
    logic [CNT_W-1:0] waitCnt;
    logic             isWait;
    logic             timedOut;
    logic             isIllegal;

    // Next-state decision; a timeout in any wait state overrides and returns to FETCH.
    always_comb begin
        nextState = FETCH;
        isIllegal = 1'b0;
        isWait    = (curState == FETCH) || (curState == MEMRD) || (curState == MEMWR);
        timedOut  = (MEM_TIMEOUT != 0) && isWait && !mem_ready && (waitCnt == WAIT_LIMIT);
        case (curState)
            FETCH:   nextState = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_R:         nextState = EXEC;
                    OP_BEQ:       nextState = BRANCH;
`ifdef CTRL_BNE_EN
                    OP_BNE:       nextState = BRANCH;
`endif
                    OP_J:         nextState = JUMP;
                    OP_ADDI:      nextState = ADDI_EX;
                    default: begin
                        nextState = FETCH;
                        isIllegal = 1'b1;
                    end
                endcase
            end
            MEMADR:  nextState = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   nextState = mem_ready ? WB_MEM : MEMRD;
            MEMWR:   nextState = mem_ready ? FETCH : MEMWR;
            EXEC:    nextState = ALU_WB;
            ADDI_EX: nextState = ADDI_WB;
            default: nextState = FETCH;
        endcase
        if (timedOut) begin
            nextState = FETCH;
        end
    end

    // State, wait counter and the two event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curState <= FETCH;
            waitCnt  <= '0;
            mem_err  <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            curState <= nextState;
            mem_err  <= timedOut;
            illegal  <= isIllegal;
            if (timedOut || mem_ready || !isWait || (nextState != curState)) begin
                waitCnt <= '0;
            end else begin
                waitCnt <= waitCnt + CNT_W'(1);
            end
        end
    end

    // Moore output decode; reset forces every control low immediately.
    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCWriteCondNe = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        RegDst        = 1'b0;
        ALUSrcA       = 1'b0;
        PCSource      = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        state         = curState;
        if (!rst) begin
            case (curState)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE:  ALUSrcB = 2'b11;
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                WB_MEM: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                ALU_WB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCSource    = 2'b01;
                    PCWriteCond = (op == OP_BEQ);
`ifdef CTRL_BNE_EN
                    PCWriteCondNe = (op == OP_BNE);
`endif
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                ADDI_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                ADDI_WB: RegWrite = 1'b1;
                default: ;
            endcase
        end else begin
            state = 4'd0;
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle MIPS control unit: a Moore FSM that sequences each instruction over 3–5 cycles and drives the shared-ALU, single-memory multicycle datapath. It replaces the single-cycle opcode decoder. It adds two things the decoder lacks: a memory ready handshake with a timeout counter, and illegal-opcode reporting. It sits between the instruction register's opcode field and the datapath control inputs.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles with mem_ready low before abort; 0 disables the timeout.
- CNT_W, 4: timeout counter width; must satisfy 2^CNT_W > MEM_TIMEOUT.
- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  6  opcode from IR[31:26]; stable from DECODE until the next FETCH.
- mem_ready  in  1  memory completes the current read/write this cycle.
- PCWrite, PCWriteCond, PCWriteCondNe  out  1 each  unconditional PC write / write if zero / write if not zero.
- IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  out  1 each  datapath controls.
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target.
- ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded.
- state  out  4  current state encoding, for debug.
- mem_err  out  1  one-cycle pulse: a memory access was aborted by the timeout.
- illegal  out  1  one-cycle pulse: an unsupported opcode was decoded.

## Operation
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000, BNE 000101 (BNE only with the macro).
- States and encodings. Any output not listed for a state is 0.
- 0 FETCH: MemRead=1, ALUSrcB=01.
  - IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- 1 DECODE: ALUSrcB=11. Next state by op:
  - LW/SW → MEMADR; R → EXEC; BEQ/BNE → BRANCH; J → JUMP; ADDI → ADDI_EX.
  - Any other op → FETCH, with illegal pulsed.
- 2 MEMADR: ALUSrcA=1, ALUSrcB=10. LW → MEMRD, SW → MEMWR.
- 3 MEMRD: MemRead=1, IorD=1. Wait for mem_ready, then → WB_MEM.
- 4 WB_MEM: MemtoReg=1, RegWrite=1 → FETCH.
- 5 MEMWR: MemWrite=1, IorD=1. Wait for mem_ready, then → FETCH.
- 6 EXEC: ALUSrcA=1, ALUOp=10 → ALU_WB.
- 7 ALU_WB: RegDst=1, RegWrite=1 → FETCH.
- 8 BRANCH: ALUSrcA=1, ALUOp=01, PCSource=01 → FETCH.
  - BEQ asserts PCWriteCond; BNE asserts PCWriteCondNe.
- 9 JUMP: PCWrite=1, PCSource=10 → FETCH.
- 10 ADDI_EX: ALUSrcA=1, ALUSrcB=10 → ADDI_WB.
- 11 ADDI_WB: RegWrite=1 → FETCH.
- Encodings 12–15 are unreachable; if entered, next state is FETCH.
- Timeout counter, used in the wait states FETCH, MEMRD and MEMWR:
  - Cleared on entry to a wait state and whenever mem_ready=1.
  - Increments each wait-state cycle with mem_ready=0.
  - When it equals MEM_TIMEOUT (nonzero) and mem_ready=0, the access aborts: next state is FETCH and mem_err pulses.
  - An aborted MEMRD performs no writeback. An aborted FETCH retries, with IRWrite and PCWrite never asserted.
- mem_ready=1 in the same cycle the count hits its limit counts as completion; no abort.

## Timing
- Latencies with zero-wait memory (mem_ready held 1):
  - LW: 5 cycles. R, SW, ADDI: 4 cycles. BEQ, BNE, J: 3 cycles.
  - Each cycle of mem_ready=0 in a wait state adds one cycle.
- Outputs are combinational from state, except IRWrite and PCWrite, which are also gated by mem_ready in FETCH.
- While rst=1, every output is 0 and state=0.
- On reset release: state FETCH, counter 0, mem_err=0, illegal=0.
- Reset mid-instruction abandons the instruction immediately; no writes occur.
- illegal and mem_err are registered: each is high for exactly the first FETCH cycle after the triggering decision.

## Configuration
- CTRL_BNE_EN defined: BNE decodes DECODE → BRANCH and drives PCWriteCondNe=1 in BRANCH.
- CTRL_BNE_EN undefined: PCWriteCondNe is tied 0, and 000101 is illegal (DECODE → FETCH with an illegal pulse).

## Test plan
- Reset during MEMRD, with rst pulsed asynchronously mid-cycle → all outputs go 0 at once; after release state=0 and no RegWrite is seen.
- LW, mem_ready always 1 → state sequence 0,1,2,3,4,0; RegWrite=1, MemtoReg=1 only in state 4; 5 cycles total.
- SW with mem_ready low 3 cycles in MEMWR → state 5 held 4 cycles with MemWrite=1 and IorD=1, then FETCH.
- Opcode 111111 → DECODE → FETCH; illegal=1 for exactly one cycle; no PCWrite outside FETCH.
- MEM_TIMEOUT=3, mem_ready stuck 0 in MEMRD → after 3 wait cycles, return to FETCH, mem_err pulses once, no RegWrite.
- BNE (000101) with the macro → states 0,1,8,0, with PCWriteCondNe=1 and ALUOp=01 in state 8; without the macro → illegal pulse.
